// File: rtl/mmm_iter_scheduler.sv
// Sequencer for the 3-word bit-serial Montgomery kernel: runs DW kernel iterations
// (one per bit of X, LSB first), then a final conditional subtraction.
module mmm_iter_scheduler #(
  parameter int unsigned DW      = 6,
  parameter int unsigned W       = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   X,
  input  logic [DW-1:0]   Y,
  input  logic [DW-1:0]   M,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [DW-1:0]   result,
  output logic            k_rst,
  output logic            k_en1,
  output logic            k_en2,
  output logic            k_xi,
  output logic [DW-1:0]   k_Y,
  output logic [DW-1:0]   k_M,
  output logic [W-1:0]    k_S0,
  output logic [W-1:0]    k_S1,
  output logic [W-1:0]    k_S2,
  input  logic [3*W-1:0]  k_S_new,
  input  logic            k_done
);

  localparam int unsigned SW = 3 * W;
  localparam int unsigned IW = $clog2(DW + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StKrst, StKrun, StCapture, StReduce, StDone, StErr
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   x_q, y_q, m_q;
  logic [SW-1:0]   s_acc_q;
  logic [IW-1:0]   iter_q;
  logic [TW-1:0]   wd_q;
  logic            en_q, busy_q, done_q, err_q;
  logic [DW-1:0]   result_q;
  logic            s_ge;

  // Compare at full sum width; the low DW bits of the difference are the answer.
  assign s_ge = (s_acc_q >= {{(SW-DW){1'b0}}, m_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      m_q      <= '0;
      s_acc_q  <= '0;
      iter_q   <= '0;
      wd_q     <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x_q     <= X;
            y_q     <= Y;
            m_q     <= M;
            iter_q  <= '0;
            s_acc_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StKrst;
          end
        end
        StKrst: begin
          wd_q    <= '0;
          en_q    <= 1'b1;
          state_q <= StKrun;
        end
        StKrun: begin
          if (k_done) begin
            en_q    <= 1'b0;
            state_q <= StCapture;
          end else if (wd_q == TW'(TIMEOUT - 1)) begin
            en_q     <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            result_q <= '0;
            state_q  <= StErr;
          end else begin
            wd_q <= wd_q + TW'(1);
          end
        end
        StCapture: begin
          s_acc_q <= k_S_new;
          x_q     <= x_q >> 1;  // next X bit moves to position 0
          iter_q  <= iter_q + IW'(1);
          state_q <= (iter_q == IW'(DW - 1)) ? StReduce : StKrst;
        end
        StReduce: begin
          result_q <= s_ge ? (s_acc_q[DW-1:0] - m_q) : s_acc_q[DW-1:0];
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone, StErr: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign k_rst  = rst | (state_q == StKrst);
  assign k_en1  = en_q;
  assign k_en2  = en_q;
  assign k_xi   = x_q[0];
  assign k_Y    = y_q;
  assign k_M    = m_q;
  assign k_S0   = s_acc_q[W-1:0];
  assign k_S1   = s_acc_q[2*W-1:W];
  assign k_S2   = s_acc_q[3*W-1:2*W];
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_mmm_iter_scheduler.sv
// Directed bench for mmm_iter_scheduler with a behavioural radix-2 kernel (L=3 cycles).
module tb_mmm_iter_scheduler;

  localparam int DW      = 6;
  localparam int W       = 3;
  localparam int TIMEOUT = 8;
  localparam int SW      = 3 * W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [DW-1:0]   x_in = '0, y_in = '0, m_in = '0;
  logic            busy, done, err;
  logic [DW-1:0]   result;
  logic            k_rst, k_en1, k_en2, k_xi;
  logic [DW-1:0]   k_Y, k_M;
  logic [W-1:0]    k_S0, k_S1, k_S2;
  logic [SW-1:0]   k_S_new;
  logic            k_done;

  logic            stall = 1'b0;
  logic [1:0]      mcnt;
  logic [SW:0]     tsum;
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  mmm_iter_scheduler #(.DW(DW), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .X(x_in), .Y(y_in), .M(m_in),
    .busy(busy), .done(done), .err(err), .result(result),
    .k_rst(k_rst), .k_en1(k_en1), .k_en2(k_en2), .k_xi(k_xi),
    .k_Y(k_Y), .k_M(k_M), .k_S0(k_S0), .k_S1(k_S1), .k_S2(k_S2),
    .k_S_new(k_S_new), .k_done(k_done)
  );

  // Kernel model: S' = (S + xi*Y + q*M)/2, done seen on the 3rd enabled cycle.
  always_comb begin
    tsum = {1'b0, k_S2, k_S1, k_S0} + (k_xi ? {4'b0, k_Y} : 10'd0);
    if (tsum[0]) tsum = tsum + {4'b0, k_M};
    k_S_new = tsum[SW:1];
  end

  always @(posedge clk) begin
    if (k_rst) begin
      mcnt   <= 2'd0;
      k_done <= 1'b0;
    end else if (k_en1 && !stall && !k_done) begin
      mcnt <= mcnt + 2'd1;
      if (mcnt == 2'd1) k_done <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one job and follow it to its done pulse; cycle 1 is the cycle after accept.
  task automatic run_job(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] m,
                         input bit hold, input int rp1, input int rp2,
                         output int lat, output logic [DW-1:0] res, output logic e_done,
                         output logic e_c1, output int krst_cnt, output int seq_bad,
                         output int busy_low);
    logic prev_en, prev_rst;
    for (int k = 0; k < 5 && busy; k++) step();
    x_in = x; y_in = y; m_in = m;
    start = 1'b1;
    step();
    start = hold;
    lat = -1; res = '0; e_done = 1'b0; e_c1 = err;
    krst_cnt = 0; seq_bad = 0; busy_low = 0;
    prev_en = 1'b0; prev_rst = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (!busy) busy_low++;
      if (k_rst) krst_cnt++;
      if (k_en1 && !prev_en && !prev_rst) seq_bad++;
      if (done) begin
        lat = cyc; res = result; e_done = err;
        break;
      end
      prev_en = k_en1; prev_rst = k_rst;
      start = hold || (cyc == rp1) || (cyc == rp2);
      step();
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if ({busy, done, err, k_en1, k_en2, k_xi} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000", {busy, done, err, k_en1, k_en2, k_xi});
    end
    total++;
    if (result !== 6'd0) begin bad++; $display("FAIL reset_result got=%0d want=0", result); end
    total++;
    if (k_rst !== 1'b1) begin bad++; $display("FAIL reset_krst got=%b want=1", k_rst); end
    rst = 1'b0;
    step();
    total++;
    if (k_rst !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset got k_rst=%b busy=%b want 0 0", k_rst, busy);
    end
  endtask

  task automatic test_basic();
    int lat, kc, sb, bl; logic [DW-1:0] res; logic ed, e1;
    run_job(6'd5, 6'd7, 6'd13, 1'b0, 0, 0, lat, res, ed, e1, kc, sb, bl);
    total++;
    if (lat !== 32) begin bad++; $display("FAIL basic_latency got=%0d want=32", lat); end
    total++;
    if (res !== 6'd4) begin bad++; $display("FAIL basic_result got=%0d want=4", res); end
    total++;
    if (ed !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", ed); end
    total++;
    if (bl !== 0) begin bad++; $display("FAIL basic_busy_low got=%0d want=0", bl); end
    total++;
    if (kc !== 6 || sb !== 0) begin
      bad++; $display("FAIL basic_krst got count=%0d badseq=%0d want 6 0", kc, sb);
    end
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL basic_drop got busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (result !== 6'd4) begin bad++; $display("FAIL basic_hold got=%0d want=4", result); end
  endtask

  task automatic test_vectors();
    logic [DW-1:0] vx[3], vy[3], vm[3], vr[3];
    int lat, kc, sb, bl; logic [DW-1:0] res; logic ed, e1;
    vx = '{6'd1, 6'd0, 6'd60};
    vy = '{6'd1, 6'd45, 6'd50};
    vm = '{6'd13, 6'd59, 6'd61};
    vr = '{6'd12, 6'd0, 6'd24};
    for (int i = 0; i < 3; i++) begin
      run_job(vx[i], vy[i], vm[i], 1'b0, 0, 0, lat, res, ed, e1, kc, sb, bl);
      total++;
      if (res !== vr[i] || lat !== 32) begin
        bad++; $display("FAIL vector%0d got res=%0d lat=%0d want res=%0d lat=32", i, res, lat, vr[i]);
      end
      total++;
      if (kc !== 6 || sb !== 0) begin
        bad++; $display("FAIL vector%0d_krst got count=%0d badseq=%0d want 6 0", i, kc, sb);
      end
    end
  endtask

  task automatic test_timeout();
    int lat, kc, sb, bl; logic [DW-1:0] res; logic ed, e1;
    stall = 1'b1;
    run_job(6'd5, 6'd7, 6'd13, 1'b0, 0, 0, lat, res, ed, e1, kc, sb, bl);
    total++;
    if (lat !== 10 || ed !== 1'b1) begin
      bad++; $display("FAIL timeout_done got lat=%0d err=%b want lat=10 err=1", lat, ed);
    end
    total++;
    if (res !== 6'd0) begin bad++; $display("FAIL timeout_result got=%0d want=0", res); end
    step(); step(); step();
    total++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky got busy=%b err=%b want 0 1", busy, err);
    end
    stall = 1'b0;
    run_job(6'd5, 6'd7, 6'd13, 1'b0, 0, 0, lat, res, ed, e1, kc, sb, bl);
    total++;
    if (e1 !== 1'b0 || ed !== 1'b0) begin
      bad++; $display("FAIL timeout_clear got err_c1=%b err_done=%b want 0 0", e1, ed);
    end
    total++;
    if (res !== 6'd4) begin bad++; $display("FAIL timeout_recover got=%0d want=4", res); end
  endtask

  task automatic test_ignore_start();
    int lat, kc, sb, bl; logic [DW-1:0] res; logic ed, e1;
    run_job(6'd5, 6'd7, 6'd13, 1'b0, 5, 20, lat, res, ed, e1, kc, sb, bl);
    total++;
    if (lat !== 32 || res !== 6'd4) begin
      bad++; $display("FAIL ignore_start got lat=%0d res=%0d want 32 4", lat, res);
    end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_start_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, kc, sb, bl, lat2; logic [DW-1:0] res; logic ed, e1;
    run_job(6'd5, 6'd7, 6'd13, 1'b1, 0, 0, lat, res, ed, e1, kc, sb, bl);
    total++;
    if (lat !== 32 || res !== 6'd4) begin
      bad++; $display("FAIL b2b_first got lat=%0d res=%0d want 32 4", lat, res);
    end
    x_in = 6'd1; y_in = 6'd1; m_in = 6'd13;
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_gap got busy=%b want 0", busy); end
    step();
    total++;
    if (busy !== 1'b1 || k_rst !== 1'b1) begin
      bad++; $display("FAIL b2b_accept got busy=%b k_rst=%b want 1 1", busy, k_rst);
    end
    start = 1'b0;
    lat2 = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (done) begin lat2 = cyc; break; end
      step();
    end
    total++;
    if (lat2 !== 32 || result !== 6'd12) begin
      bad++; $display("FAIL b2b_second got lat=%0d res=%0d want 32 12", lat2, result);
    end
  endtask

  task automatic test_mid_reset();
    int lat, kc, sb, bl, seen; logic [DW-1:0] res; logic ed, e1;
    for (int k = 0; k < 5 && busy; k++) step();
    x_in = 6'd5; y_in = 6'd7; m_in = 6'd13;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 12; cyc++) step();
    rst = 1'b1;
    #1;
    total++;
    if (k_rst !== 1'b1) begin bad++; $display("FAIL midrst_krst got=%b want=1", k_rst); end
    step();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || k_en1 !== 1'b0) begin
      bad++; $display("FAIL midrst_idle got busy=%b done=%b en=%b want 0 0 0", busy, done, k_en1);
    end
    seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done || busy) seen++;
      step();
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midrst_dropped got=%0d want=0", seen); end
    run_job(6'd5, 6'd7, 6'd13, 1'b0, 0, 0, lat, res, ed, e1, kc, sb, bl);
    total++;
    if (res !== 6'd4 || lat !== 32) begin
      bad++; $display("FAIL midrst_fresh got res=%0d lat=%0d want 4 32", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_timeout();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmm_iter_scheduler.md
Name: mmm_iter_scheduler

Overview:
- Sequencing controller for the 3-word bit-serial Montgomery kernel (radix-2, e=3 words of W bits).
- Accepts one X*Y*2^-DW mod M job per start handshake.
- Runs DW kernel iterations, one per bit of X (LSB first). Each iteration clears the kernel, drives xi and the running sum, waits for the kernel done, then captures S_new.
- Finishes with a final conditional subtraction. Sits between the host/accelerator front end and the kernel instance; a watchdog reports stuck iterations.

Parameters:
- DW, 6, operand width in bits. Constraint: ceil((DW+1)/W) == 3.
- W, 3, kernel word width in bits.
- TIMEOUT, 64, maximum KRUN cycles per iteration before error (>= 2).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  job request, sampled only in IDLE
- X  in  DW  multiplier, latched on accept
- Y  in  DW  multiplicand, latched on accept
- M  in  DW  odd modulus, latched on accept
- busy  out  1  high from accept until the cycle after done
- done  out  1  one-cycle completion pulse
- err  out  1  watchdog error, sticky until next accepted start
- result  out  DW  final product, valid while done=1, held until next accept
- k_rst  out  1  kernel clear
- k_en1  out  1  kernel pe0 enable
- k_en2  out  1  kernel pe1 enable
- k_xi  out  1  current X bit
- k_Y  out  DW  latched Y
- k_M  out  DW  latched M
- k_S0  out  W  running-sum word 0
- k_S1  out  W  running-sum word 1
- k_S2  out  W  running-sum word 2
- k_S_new  in  3W  kernel iteration result {S2,S1,S0}
- k_done  in  1  kernel iteration complete, sticky until k_rst

Behaviour:
- Reset values: busy=0, done=0, err=0, result=0, k_en1=k_en2=0, k_xi=0, S_acc=0, iteration index i=0, state=IDLE.
- k_rst = rst OR (state==KRST), registered-state decode. rst therefore also clears the kernel.
- State machine and transitions:
  - IDLE: if start=1, latch X/Y/M, set i=0, S_acc=0, clear err, then go to KRST. Otherwise stay.
  - KRST: one cycle; k_rst=1. Then go to KRUN.
  - KRUN: k_en1=k_en2=1. The watchdog counts from 0 each iteration.
    - k_done=1 goes to CAPTURE.
    - Otherwise, watchdog == TIMEOUT-1 goes to ERR.
    - k_done wins if both occur in the same cycle.
  - CAPTURE: S_acc <= k_S_new, i <= i+1. If i==DW-1 go to REDUCE, else go to KRST.
  - REDUCE: result <= (S_acc >= {0,M}) ? S_acc - M : S_acc, truncated to DW bits. Compare at 3W bits with M zero-extended. Then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
  - ERR: done=1 and err=1 (err remains sticky), result <= 0, then go to IDLE.
- Held kernel inputs:
  - k_xi = X_reg[i], k_S0/k_S1/k_S2 = S_acc words 0/1/2, k_Y=Y_reg, k_M=M_reg.
  - All stable through KRST and KRUN of an iteration.
  - Values in other states are don't-care but must not glitch during KRUN.
- Latency: let L = number of KRUN cycles per iteration (k_done seen on the L-th). done asserts in the (DW*(L+2)+2)-th cycle after the accepting edge.
- busy=1 in every state except IDLE. It drops in the cycle after the done pulse.
- start while busy is ignored; no queueing. start held high continuously re-launches immediately from IDLE; back-to-back jobs have 1 idle cycle.
- Arithmetic: the kernel guarantees S_acc < 2M, so one subtraction suffices. The 3W-bit S_acc never overflows under the DW constraint.
- rst asserted mid-operation: the next cycle is IDLE with all reset values. The kernel is cleared via k_rst; any in-flight job is dropped with no done pulse.
- k_done already high on entry to KRUN (kernel not cleared) is accepted. The bench must flag it only if it precedes KRST.

Test Plan:
- Bench uses a behavioural kernel model: S' = (S + xi*Y + q*M)/2 with q = LSB(S + xi*Y), k_done after L=3 cycles. DW=6, W=3.
- X=5, Y=7, M=13, start pulse -> done pulse at cycle 6*5+2=32 after accept; result=4; err=0; busy high cycles 1..32.
- X=1, Y=1, M=13 -> result=12 (2^-6 mod 13). X=0, Y=45, M=59 -> result=0. Every iteration shows k_rst high for exactly one cycle before KRUN.
- Model never asserts k_done, TIMEOUT=8 -> done=1 and err=1 after 1+8 cycles, result=0. err stays 1 until the next start, then clears on accept.
- start re-pulsed at cycles 5 and 20 of a job -> ignored; result and latency unchanged. start held high -> second job accepted the cycle after done.
- rst asserted at cycle 12 of a job -> next cycle busy=0, done=0, state IDLE, k_rst=1 during rst. A fresh job (X=5, Y=7, M=13) afterwards yields 4.
